vtp_lookup_dedup_filter: RTL and testbench



---
 rtl/vtp_lookup_dedup_filter.sv | 229 ++++++++++++++++++++++
 tb/tb_vtp_lookup_dedup_filter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vtp_lookup_dedup_filter.sv
// VTP lookup dedup filter: merges back-to-back same-page lookups into one server request
// and fans the server response out to every merged tag. Optional VTP_DEDUP_STATS_EN adds dup_count.
module vtp_lookup_dedup_filter #(
    parameter int TAG_BITS     = 5,
    parameter int VA_BITS      = 36,
    parameter int PA_BITS      = 32,
    parameter int REQ_AUX_BITS = 1,
    parameter int RSP_AUX_BITS = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    c_req_en,
    output logic                    c_req_rdy,
    input  logic [TAG_BITS-1:0]     c_req_tag,
    input  logic [VA_BITS-1:0]      c_req_va,
    input  logic                    c_req_spec,
    input  logic [REQ_AUX_BITS-1:0] c_req_aux,
    output logic                    s_req_en,
    input  logic                    s_req_rdy,
    output logic [TAG_BITS-1:0]     s_req_tag,
    output logic [VA_BITS-1:0]      s_req_va,
    output logic                    s_req_spec,
    output logic [REQ_AUX_BITS-1:0] s_req_aux,
    input  logic                    s_rsp_valid,
    input  logic [TAG_BITS-1:0]     s_rsp_tag,
    input  logic [PA_BITS-1:0]      s_rsp_pa,
    input  logic                    s_rsp_may_cache,
    input  logic [RSP_AUX_BITS-1:0] s_rsp_aux,
    output logic                    c_rsp_valid,
    output logic [TAG_BITS-1:0]     c_rsp_tag,
    output logic [PA_BITS-1:0]      c_rsp_pa,
    output logic                    c_rsp_may_cache,
    output logic [RSP_AUX_BITS-1:0] c_rsp_aux
`ifdef VTP_DEDUP_STATS_EN
    ,
    output logic [31:0]             dup_count
`endif
);

    localparam int N_TAGS = 2 ** TAG_BITS;

    typedef struct packed {
        logic                    match;
        logic [TAG_BITS-1:0]     tag;
        logic [VA_BITS-1:0]      va;
        logic                    spec;
        logic [REQ_AUX_BITS-1:0] aux;
    } req_t;

    typedef struct packed {
        logic [TAG_BITS-1:0]     tag;
        logic [PA_BITS-1:0]      pa;
        logic                    may_cache;
        logic [RSP_AUX_BITS-1:0] aux;
    } rsp_t;

    logic [VA_BITS-1:0]  prev_va_r;
    logic                prev_spec_r;
    logic                match_s;
    logic                push_s;
    req_t                req_mem_r [2];
    logic                req_wr_ptr_r;
    logic                req_rd_ptr_r;
    logic [1:0]          req_count_r;
    logic                head_valid_s;
    req_t                head_s;
    logic                deq_s;
    logic                dup_s;
    logic                cur_valid_r;
    logic [TAG_BITS-1:0] cur_tag_r;
    logic [TAG_BITS-1:0] cur_tail_r;
    logic [TAG_BITS-1:0] next_ptr_r [N_TAGS];
    logic [TAG_BITS-1:0] tail_ptr_r [N_TAGS];
    rsp_t                rsp_mem_r [N_TAGS];
    logic [TAG_BITS-1:0] rsp_wr_ptr_r;
    logic [TAG_BITS-1:0] rsp_rd_ptr_r;
    logic [TAG_BITS:0]   rsp_count_r;
    logic                rsp_head_valid_s;
    rsp_t                rsp_head_s;
    logic                rsp_pop_s;
    logic                out_valid_r;
    rsp_t                out_rsp_r;
    logic [TAG_BITS-1:0] out_tail_r;
    logic                active_s;

    // The match bit compares against the request seen just before this one, not against the base.
    assign match_s      = (c_req_va == prev_va_r) && (c_req_spec == prev_spec_r);
    assign c_req_rdy    = (req_count_r != 2'd2);
    assign push_s       = c_req_en && c_req_rdy;
    assign head_valid_s = (req_count_r != 2'd0);
    assign head_s       = req_mem_r[req_rd_ptr_r];
    assign deq_s        = head_valid_s && s_req_rdy;
    assign dup_s        = cur_valid_r && head_s.match;

    assign s_req_en   = deq_s && !dup_s;
    assign s_req_tag  = head_s.tag;
    assign s_req_va   = head_s.va;
    assign s_req_spec = head_s.spec;
    assign s_req_aux  = head_s.aux;

    // Previous-request page tracker.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_va_r   <= '0;
            prev_spec_r <= 1'b0;
        end else if (c_req_en) begin
            prev_va_r   <= c_req_va;
            prev_spec_r <= c_req_spec;
        end
    end

    // Request FIFO storage.
    always_ff @(posedge clk) begin
        if (push_s) begin
            req_mem_r[req_wr_ptr_r] <= '{match: match_s, tag: c_req_tag, va: c_req_va,
                                         spec: c_req_spec, aux: c_req_aux};
        end
    end

    // Request FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_wr_ptr_r <= 1'b0;
            req_rd_ptr_r <= 1'b0;
            req_count_r  <= 2'd0;
        end else begin
            if (push_s) req_wr_ptr_r <= ~req_wr_ptr_r;
            if (deq_s)  req_rd_ptr_r <= ~req_rd_ptr_r;
            case ({push_s, deq_s})
                2'b10:   req_count_r <= req_count_r + 2'd1;
                2'b01:   req_count_r <= req_count_r - 2'd1;
                default: req_count_r <= req_count_r;
            endcase
        end
    end

    // Current base tracking; a newly dequeued base wins over the old base's response.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_valid_r <= 1'b0;
            cur_tag_r   <= '0;
            cur_tail_r  <= '0;
        end else begin
            if (deq_s && !dup_s) begin
                cur_valid_r <= 1'b1;
                cur_tag_r   <= head_s.tag;
            end else if (s_rsp_valid && (s_rsp_tag == cur_tag_r)) begin
                cur_valid_r <= 1'b0;
            end
            if (deq_s) cur_tail_r <= head_s.tag;
        end
    end

    // Chain link and chain tail LUTRAMs; a lone base records itself as its own tail.
    always_ff @(posedge clk) begin
        if (deq_s && dup_s) next_ptr_r[cur_tail_r] <= head_s.tag;
        if (deq_s) tail_ptr_r[dup_s ? cur_tag_r : head_s.tag] <= head_s.tag;
    end

    assign rsp_head_valid_s = (rsp_count_r != (TAG_BITS + 1)'(0));
    assign rsp_head_s       = rsp_mem_r[rsp_rd_ptr_r];
    assign active_s         = out_valid_r && (out_tail_r != out_rsp_r.tag);
    assign rsp_pop_s        = rsp_head_valid_s && !active_s;

    // Response FIFO storage; at most N_TAGS responses can be outstanding so it never overflows.
    always_ff @(posedge clk) begin
        if (s_rsp_valid) begin
            rsp_mem_r[rsp_wr_ptr_r] <= '{tag: s_rsp_tag, pa: s_rsp_pa,
                                         may_cache: s_rsp_may_cache, aux: s_rsp_aux};
        end
    end

    // Response FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_wr_ptr_r <= '0;
            rsp_rd_ptr_r <= '0;
            rsp_count_r  <= '0;
        end else begin
            if (s_rsp_valid) rsp_wr_ptr_r <= rsp_wr_ptr_r + TAG_BITS'(1);
            if (rsp_pop_s)   rsp_rd_ptr_r <= rsp_rd_ptr_r + TAG_BITS'(1);
            case ({s_rsp_valid, rsp_pop_s})
                2'b10:   rsp_count_r <= rsp_count_r + (TAG_BITS + 1)'(1);
                2'b01:   rsp_count_r <= rsp_count_r - (TAG_BITS + 1)'(1);
                default: rsp_count_r <= rsp_count_r;
            endcase
        end
    end

    // Output stage: walk the chain one tag per cycle, duplicates never report may_cache.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_rsp_r   <= '0;
            out_tail_r  <= '0;
        end else if (active_s) begin
            out_rsp_r.tag       <= next_ptr_r[out_rsp_r.tag];
            out_rsp_r.may_cache <= 1'b0;
        end else if (rsp_head_valid_s) begin
            out_valid_r <= 1'b1;
            out_rsp_r   <= rsp_head_s;
            out_tail_r  <= tail_ptr_r[rsp_head_s.tag];
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign c_rsp_valid     = out_valid_r;
    assign c_rsp_tag       = out_rsp_r.tag;
    assign c_rsp_pa        = out_rsp_r.pa;
    assign c_rsp_may_cache = out_rsp_r.may_cache;
    assign c_rsp_aux       = out_rsp_r.aux;

`ifdef VTP_DEDUP_STATS_EN
    logic [31:0] dup_count_r;

    // Saturating count of merged duplicates.
    always_ff @(posedge clk) begin
        if (reset) begin
            dup_count_r <= 32'd0;
        end else if (deq_s && dup_s && (dup_count_r != 32'hFFFF_FFFF)) begin
            dup_count_r <= dup_count_r + 32'd1;
        end
    end

    assign dup_count = dup_count_r;
`endif

endmodule

// File: tb/tb_vtp_lookup_dedup_filter.sv
// Scoreboard bench for vtp_lookup_dedup_filter: expected server requests and client
// responses (with their due cycle) are queued as stimulus is driven and checked on output.
module tb_vtp_lookup_dedup_filter;

    logic        clk = 1'b0;
    logic        reset;
    logic        c_req_en;
    logic        c_req_rdy;
    logic [4:0]  c_req_tag;
    logic [35:0] c_req_va;
    logic        c_req_spec;
    logic [0:0]  c_req_aux;
    logic        s_req_en;
    logic        s_req_rdy;
    logic [4:0]  s_req_tag;
    logic [35:0] s_req_va;
    logic        s_req_spec;
    logic [0:0]  s_req_aux;
    logic        s_rsp_valid;
    logic [4:0]  s_rsp_tag;
    logic [31:0] s_rsp_pa;
    logic        s_rsp_may_cache;
    logic [0:0]  s_rsp_aux;
    logic        c_rsp_valid;
    logic [4:0]  c_rsp_tag;
    logic [31:0] c_rsp_pa;
    logic        c_rsp_may_cache;
    logic [0:0]  c_rsp_aux;
`ifdef VTP_DEDUP_STATS_EN
    logic [31:0] dup_count;
`endif

    vtp_lookup_dedup_filter dut (
        .clk(clk), .reset(reset),
        .c_req_en(c_req_en), .c_req_rdy(c_req_rdy), .c_req_tag(c_req_tag),
        .c_req_va(c_req_va), .c_req_spec(c_req_spec), .c_req_aux(c_req_aux),
        .s_req_en(s_req_en), .s_req_rdy(s_req_rdy), .s_req_tag(s_req_tag),
        .s_req_va(s_req_va), .s_req_spec(s_req_spec), .s_req_aux(s_req_aux),
        .s_rsp_valid(s_rsp_valid), .s_rsp_tag(s_rsp_tag), .s_rsp_pa(s_rsp_pa),
        .s_rsp_may_cache(s_rsp_may_cache), .s_rsp_aux(s_rsp_aux),
        .c_rsp_valid(c_rsp_valid), .c_rsp_tag(c_rsp_tag), .c_rsp_pa(c_rsp_pa),
        .c_rsp_may_cache(c_rsp_may_cache), .c_rsp_aux(c_rsp_aux)
`ifdef VTP_DEDUP_STATS_EN
        , .dup_count(dup_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } rsp_exp_t;

    logic [63:0] sreq_q [$];
    rsp_exp_t    rsp_q [$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_value(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic exp_sreq(input logic [4:0] tag, input logic [35:0] va, input logic spec,
                            input logic aux);
        sreq_q.push_back({21'd0, tag, va, spec, aux});
    endtask

    task automatic exp_rsp(input logic [4:0] tag, input logic [31:0] pa, input logic mc,
                           input logic aux, input int due);
        rsp_exp_t e;
        e.data = {25'd0, tag, pa, mc, aux};
        e.cyc  = due;
        rsp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_req(input logic [4:0] tag, input logic [35:0] va, input logic spec,
                            input logic aux);
        int budget = 50;
        while (!c_req_rdy && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        check_value("req_rdy_wait", {63'd0, c_req_rdy}, 64'd1);
        c_req_en   = 1'b1;
        c_req_tag  = tag;
        c_req_va   = va;
        c_req_spec = spec;
        c_req_aux  = aux;
        @(posedge clk);
        #1;
        c_req_en = 1'b0;
    endtask

    task automatic send_rsp(input logic [4:0] tag, input logic [31:0] pa, input logic mc,
                            input logic aux);
        s_rsp_valid     = 1'b1;
        s_rsp_tag       = tag;
        s_rsp_pa        = pa;
        s_rsp_may_cache = mc;
        s_rsp_aux       = aux;
        @(posedge clk);
        #1;
        s_rsp_valid = 1'b0;
    endtask

    // Output monitor: compare DUT traffic against the scoreboard heads.
    always @(negedge clk) begin
        if (!reset) begin
            if (!s_req_rdy) check_value("sreq_en_no_rdy", {63'd0, s_req_en}, 64'd0);
            if (s_req_en) begin
                if (sreq_q.size() == 0) begin
                    check_value("sreq_unexpected", {59'd0, s_req_tag}, 64'hFFFF);
                end else begin
                    check_value("sreq", {21'd0, s_req_tag, s_req_va, s_req_spec, s_req_aux},
                                sreq_q.pop_front());
                end
            end
            if (c_rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    check_value("crsp_unexpected", {59'd0, c_rsp_tag}, 64'hFFFF);
                end else begin
                    rsp_exp_t e;
                    e = rsp_q.pop_front();
                    check_value("crsp", {25'd0, c_rsp_tag, c_rsp_pa, c_rsp_may_cache, c_rsp_aux},
                                e.data);
                    check_value("crsp_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; c_req_en = 1'b0; c_req_tag = '0; c_req_va = '0; c_req_spec = 1'b0;
        c_req_aux = '0; s_req_rdy = 1'b1; s_rsp_valid = 1'b0; s_rsp_tag = '0; s_rsp_pa = '0;
        s_rsp_may_cache = 1'b0; s_rsp_aux = '0;
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_c_rsp_valid", {63'd0, c_rsp_valid}, 64'd0);
        check_value("rst_c_rsp_fields", {25'd0, c_rsp_tag, c_rsp_pa, c_rsp_may_cache, c_rsp_aux}, 64'd0);
        check_value("rst_c_req_rdy", {63'd0, c_req_rdy}, 64'd1);
        check_value("rst_s_req_en", {63'd0, s_req_en}, 64'd0);
`ifdef VTP_DEDUP_STATS_EN
        check_value("rst_dup_count", {32'd0, dup_count}, 64'd0);
`endif
        reset = 1'b0;

        // Single lookup.
        exp_sreq(5'd3, 36'h100, 1'b0, 1'b1);
        send_req(5'd3, 36'h100, 1'b0, 1'b1);
        idle(2);
        n = cyc; exp_rsp(5'd3, 32'h55, 1'b1, 1'b0, n + 2);
        send_rsp(5'd3, 32'h55, 1'b1, 1'b0);
        idle(5);

        // Three-way merge.
        exp_sreq(5'd1, 36'h200, 1'b0, 1'b0);
        send_req(5'd1, 36'h200, 1'b0, 1'b0);
        send_req(5'd2, 36'h200, 1'b0, 1'b1);
        send_req(5'd4, 36'h200, 1'b0, 1'b0);
        idle(3);
        n = cyc;
        exp_rsp(5'd1, 32'h7, 1'b1, 1'b1, n + 2);
        exp_rsp(5'd2, 32'h7, 1'b0, 1'b1, n + 3);
        exp_rsp(5'd4, 32'h7, 1'b0, 1'b1, n + 4);
        send_rsp(5'd1, 32'h7, 1'b1, 1'b1);
        idle(6);
`ifdef VTP_DEDUP_STATS_EN
        check_value("dup_count_merge3", {32'd0, dup_count}, 64'd2);
`endif

        // Same VA, different spec: both forwarded; tag 5 matches prev but no base is live.
        exp_sreq(5'd5, 36'h200, 1'b0, 1'b0);
        exp_sreq(5'd6, 36'h200, 1'b1, 1'b0);
        send_req(5'd5, 36'h200, 1'b0, 1'b0);
        send_req(5'd6, 36'h200, 1'b1, 1'b0);
        idle(3);
        n = cyc;
        exp_rsp(5'd5, 32'h11, 1'b1, 1'b0, n + 2);
        exp_rsp(5'd6, 32'h12, 1'b0, 1'b1, n + 3);
        send_rsp(5'd5, 32'h11, 1'b1, 1'b0);
        send_rsp(5'd6, 32'h12, 1'b0, 1'b1);
        idle(5);

        // Response clears the base, so a later same-page lookup is forwarded.
        exp_sreq(5'd1, 36'h300, 1'b0, 1'b0);
        send_req(5'd1, 36'h300, 1'b0, 1'b0);
        idle(2);
        n = cyc; exp_rsp(5'd1, 32'h9, 1'b0, 1'b0, n + 2);
        send_rsp(5'd1, 32'h9, 1'b0, 1'b0);
        exp_sreq(5'd2, 36'h300, 1'b0, 1'b1);
        send_req(5'd2, 36'h300, 1'b0, 1'b1);
        idle(2);
        n = cyc; exp_rsp(5'd2, 32'hA, 1'b1, 1'b0, n + 2);
        send_rsp(5'd2, 32'hA, 1'b1, 1'b0);
        idle(5);

        // Server back-pressure fills the 2-entry request FIFO.
        s_req_rdy = 1'b0;
        exp_sreq(5'd7, 36'h500, 1'b0, 1'b0);
        exp_sreq(5'd8, 36'h600, 1'b0, 1'b0);
        exp_sreq(5'd9, 36'h700, 1'b0, 1'b0);
        send_req(5'd7, 36'h500, 1'b0, 1'b0);
        send_req(5'd8, 36'h600, 1'b0, 1'b0);
        check_value("req_full_rdy", {63'd0, c_req_rdy}, 64'd0);
        idle(3);
        check_value("req_still_full", {63'd0, c_req_rdy}, 64'd0);
        s_req_rdy = 1'b1;
        send_req(5'd9, 36'h700, 1'b0, 1'b0);
        idle(3);
        n = cyc;
        exp_rsp(5'd7, 32'h70, 1'b1, 1'b0, n + 2);
        exp_rsp(5'd8, 32'h80, 1'b1, 1'b0, n + 3);
        exp_rsp(5'd9, 32'h90, 1'b1, 1'b0, n + 4);
        send_rsp(5'd7, 32'h70, 1'b1, 1'b0);
        send_rsp(5'd8, 32'h80, 1'b1, 1'b0);
        send_rsp(5'd9, 32'h90, 1'b1, 1'b0);
        idle(6);

        // Chain fan-out back-pressures a second response.
        exp_sreq(5'd10, 36'h800, 1'b0, 1'b0);
        exp_sreq(5'd13, 36'h900, 1'b0, 1'b0);
        send_req(5'd10, 36'h800, 1'b0, 1'b0);
        send_req(5'd11, 36'h800, 1'b0, 1'b0);
        send_req(5'd12, 36'h800, 1'b0, 1'b0);
        send_req(5'd13, 36'h900, 1'b0, 1'b0);
        idle(3);
        n = cyc;
        exp_rsp(5'd10, 32'h21, 1'b1, 1'b0, n + 2);
        exp_rsp(5'd11, 32'h21, 1'b0, 1'b0, n + 3);
        exp_rsp(5'd12, 32'h21, 1'b0, 1'b0, n + 4);
        exp_rsp(5'd13, 32'h22, 1'b1, 1'b1, n + 5);
        send_rsp(5'd10, 32'h21, 1'b1, 1'b0);
        send_rsp(5'd13, 32'h22, 1'b1, 1'b1);
        idle(7);
`ifdef VTP_DEDUP_STATS_EN
        check_value("dup_count_chain", {32'd0, dup_count}, 64'd4);
`endif

        // Duplicate dequeued in the same cycle as its base response still chains.
        exp_sreq(5'd14, 36'hA00, 1'b0, 1'b0);
        send_req(5'd14, 36'hA00, 1'b0, 1'b0);
        idle(2);
        send_req(5'd15, 36'hA00, 1'b0, 1'b1);
        n = cyc;
        exp_rsp(5'd14, 32'h33, 1'b1, 1'b0, n + 2);
        exp_rsp(5'd15, 32'h33, 1'b0, 1'b0, n + 3);
        send_rsp(5'd14, 32'h33, 1'b1, 1'b0);
        idle(6);

        // New base dequeued as the old base's response arrives: new base stays live.
        exp_sreq(5'd16, 36'hB00, 1'b0, 1'b0);
        exp_sreq(5'd17, 36'hC00, 1'b0, 1'b0);
        send_req(5'd16, 36'hB00, 1'b0, 1'b0);
        idle(2);
        send_req(5'd17, 36'hC00, 1'b0, 1'b0);
        n = cyc; exp_rsp(5'd16, 32'h44, 1'b1, 1'b0, n + 2);
        send_rsp(5'd16, 32'h44, 1'b1, 1'b0);
        send_req(5'd18, 36'hC00, 1'b0, 1'b0);
        idle(3);
        n = cyc;
        exp_rsp(5'd17, 32'h45, 1'b1, 1'b1, n + 2);
        exp_rsp(5'd18, 32'h45, 1'b0, 1'b1, n + 3);
        send_rsp(5'd17, 32'h45, 1'b1, 1'b1);
        idle(8);

        check_value("sreq_q_drained", 64'(sreq_q.size()), 64'd0);
        check_value("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
`ifdef VTP_DEDUP_STATS_EN
        check_value("dup_count_final", {32'd0, dup_count}, 64'd6);
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
